// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyser capture sequencer.
package la_pkg;

  localparam int LA_CH     = 8;
  localparam int LA_ADDR_W = 17;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } la_state_t;

  // States in which incoming samples are written to the sample RAM.
  function automatic logic is_capture(input la_state_t s);
    return (s == S_PRE) || (s == S_WAIT) || (s == S_POST);
  endfunction

endpackage

// File: rtl/la_trig_match.sv
// Trigger matcher: per-channel level/edge compare against the previous stored sample.
module la_trig_match
  import la_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             smp,
  input  logic [LA_CH-1:0] din,
  input  logic [LA_CH-1:0] trig_mask,
  input  logic [LA_CH-1:0] trig_val,
  input  logic [LA_CH-1:0] trig_edge,
  input  logic             force_trig,
  output logic             trig
);

  logic [LA_CH-1:0] prev;
  logic             prev_valid;
  logic             lvl;
  logic             edg;

  // Remember the last stored sample; the history is invalid until the first sample after arm.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev       <= '0;
      prev_valid <= 1'b0;
    end else if (clr) begin
      prev_valid <= 1'b0;
    end else if (smp) begin
      prev       <= din;
      prev_valid <= 1'b1;
    end
  end

  // Level match on masked channels, edge match on any enabled channel changing.
  always_comb begin
    lvl  = &(~trig_mask | ~(din ^ trig_val));
    edg  = (trig_edge == '0) | (|((din ^ prev) & trig_edge));
    trig = (lvl & edg & prev_valid & (|(trig_mask | trig_edge))) | force_trig;
  end

endmodule

// File: rtl/la_capture_ctrl.sv
// Capture sequencer for the 8-channel logic analyser: circular sample RAM fill with a
// fixed pre-trigger depth, trigger detection and post-trigger count, then freeze.
// Optional build macro LA_AUTO_TRIG_EN adds a sample-count auto-trigger in S_WAIT.
//
//   state  | meaning
//   S_IDLE | not capturing, waiting for arm
//   S_PRE  | filling the pre-trigger history
//   S_WAIT | writing continuously, looking for the trigger
//   S_POST | counting post-trigger samples
//   S_DONE | RAM frozen, stop raised, window base valid
module la_capture_ctrl
  import la_pkg::*;
#(
  parameter int ADDR_W   = LA_ADDR_W,
  parameter int PRE_TRIG = 16384,
  parameter int TIMEOUT  = 2**20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_en,
  input  logic [LA_CH-1:0]  din,
  input  logic              arm,
  input  logic              abort,
  input  logic              force_trig,
  input  logic [LA_CH-1:0]  trig_mask,
  input  logic [LA_CH-1:0]  trig_val,
  input  logic [LA_CH-1:0]  trig_edge,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [LA_CH-1:0]  wr_data,
  output logic              stop,
  output logic [ADDR_W-1:0] rd_base,
  output logic [ADDR_W-1:0] trig_addr,
  output logic [2:0]        state_o,
  output logic              done_p
);

  localparam int DEPTH = 2**ADDR_W;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [ADDR_W:0]   cnt_t;

  localparam cnt_t PRE_LEN  = cnt_t'(PRE_TRIG);
  localparam cnt_t POST_LEN = cnt_t'(DEPTH - PRE_TRIG);

  la_state_t state, state_nxt;
  addr_t     ptr;
  addr_t     trig_ptr;
  addr_t     trig_src;
  cnt_t      pre_cnt;
  cnt_t      post_cnt;
  logic      smp;
  logic      accept_arm;
  logic      match_trig;
  logic      auto_trig;
  logic      trig_fire;
  logic      done_entry;

  assign smp        = sample_en & is_capture(state) & ~abort;
  assign accept_arm = arm & ~abort & ((state == S_IDLE) | (state == S_DONE));
  assign trig_fire  = smp & (state == S_WAIT) & (match_trig | auto_trig);
  assign done_entry = (state_nxt == S_DONE) & (state != S_DONE);
  // A capture whose post length is one completes on the trigger sample itself.
  assign trig_src   = (state == S_WAIT) ? ptr : trig_ptr;
  assign stop       = (state == S_DONE);
  assign state_o    = state;

  la_trig_match u_match (
    .clk        (clk),
    .rst        (rst),
    .clr        (accept_arm),
    .smp        (smp),
    .din        (din),
    .trig_mask  (trig_mask),
    .trig_val   (trig_val),
    .trig_edge  (trig_edge),
    .force_trig (force_trig),
    .trig       (match_trig)
  );

`ifdef LA_AUTO_TRIG_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  typedef logic [TO_W-1:0] to_t;
  to_t to_cnt;

  // Count samples seen in S_WAIT; restarts every time S_WAIT is entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
    end else if ((state_nxt == S_WAIT) && (state != S_WAIT)) begin
      to_cnt <= '0;
    end else if (smp && (state == S_WAIT)) begin
      to_cnt <= to_cnt + to_t'(1);
    end
  end

  assign auto_trig = (to_cnt == to_t'(TIMEOUT - 1));
`else
  // Never true: without auto-trigger S_WAIT waits indefinitely.
  assign auto_trig = (TIMEOUT < 0);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; abort overrides everything, including a simultaneous arm.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (arm) state_nxt = (PRE_TRIG == 0) ? S_WAIT : S_PRE;
        S_PRE:          if (smp && ((pre_cnt + cnt_t'(1)) == PRE_LEN)) state_nxt = S_WAIT;
        S_WAIT:         if (trig_fire) state_nxt = (POST_LEN == cnt_t'(1)) ? S_DONE : S_POST;
        S_POST:         if (smp && ((post_cnt + cnt_t'(1)) == POST_LEN)) state_nxt = S_DONE;
        default:        state_nxt = S_IDLE;
      endcase
    end
  end

  // RAM write port, write pointer, sample counters and the frozen window registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      ptr       <= '0;
      trig_ptr  <= '0;
      pre_cnt   <= '0;
      post_cnt  <= '0;
      trig_addr <= '0;
      rd_base   <= '0;
      done_p    <= 1'b0;
    end else begin
      wr_en  <= smp;
      done_p <= done_entry;
      if (smp) begin
        wr_addr <= ptr;
        wr_data <= din;
        ptr     <= ptr + addr_t'(1);
      end
      if (accept_arm)                 pre_cnt <= '0;
      else if (smp && state == S_PRE) pre_cnt <= pre_cnt + cnt_t'(1);
      if (trig_fire) begin
        trig_ptr <= ptr;
        post_cnt <= cnt_t'(1);
      end else if (smp && state == S_POST) begin
        post_cnt <= post_cnt + cnt_t'(1);
      end
      if (done_entry) begin
        trig_addr <= trig_src;
        rd_base   <= trig_src - addr_t'(PRE_TRIG);
      end
    end
  end

endmodule

// File: tb/tb_la_capture_ctrl.sv
// Scoreboard bench: two small instances (PRE_TRIG=4 and PRE_TRIG=0, 16-entry RAM).
module tb_la_capture_ctrl;

  logic       clk = 1'b0;
  logic       rst, sample_en, arm_a, arm_b, abort, force_trig;
  logic [7:0] din, trig_mask, trig_val, trig_edge;

  logic       wr_en_a, stop_a, done_p_a, wr_en_b, stop_b, done_p_b;
  logic [3:0] wr_addr_a, rd_base_a, trig_addr_a, wr_addr_b, rd_base_b, trig_addr_b;
  logic [7:0] wr_data_a, wr_data_b;
  logic [2:0] state_a, state_b;

  int n_chk = 0;
  int n_err = 0;

  logic [11:0] wq_a[$], wq_b[$];
  logic [7:0]  dq_a[$], dq_b[$];
  logic [3:0]  ptr_a = 4'd0, ptr_b = 4'd0;
  logic        cap_a = 1'b0, cap_b = 1'b0;
  logic [11:0] mw_a, mw_b;
  logic [7:0]  md_a, md_b;

  always #5 clk = ~clk;

  la_capture_ctrl #(.ADDR_W(4), .PRE_TRIG(4), .TIMEOUT(2000)) u_a (
    .clk(clk), .rst(rst), .sample_en(sample_en), .din(din), .arm(arm_a), .abort(abort),
    .force_trig(force_trig), .trig_mask(trig_mask), .trig_val(trig_val), .trig_edge(trig_edge),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a), .stop(stop_a),
    .rd_base(rd_base_a), .trig_addr(trig_addr_a), .state_o(state_a), .done_p(done_p_a)
  );

  la_capture_ctrl #(.ADDR_W(4), .PRE_TRIG(0), .TIMEOUT(8)) u_b (
    .clk(clk), .rst(rst), .sample_en(sample_en), .din(din), .arm(arm_b), .abort(abort),
    .force_trig(force_trig), .trig_mask(trig_mask), .trig_val(trig_val), .trig_edge(trig_edge),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b), .stop(stop_b),
    .rd_base(rd_base_b), .trig_addr(trig_addr_b), .state_o(state_b), .done_p(done_p_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: DUT output with nothing expected", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One sample strobe; the expected RAM write is queued for every instance that is capturing.
  task automatic do_sample(input logic [7:0] d);
    sample_en = 1'b1;
    din       = d;
    if (cap_a) begin wq_a.push_back({ptr_a, d}); ptr_a = ptr_a + 4'd1; end
    if (cap_b) begin wq_b.push_back({ptr_b, d}); ptr_b = ptr_b + 4'd1; end
    tick();
    sample_en = 1'b0;
  endtask

  // Monitor: compares every RAM write and every done pulse against the queued expectations.
  always @(negedge clk) begin
    if (wr_en_a === 1'b1) begin
      if (wq_a.size() == 0) unexpected("a_write");
      else begin
        mw_a = wq_a.pop_front();
        chk("a_wr_addr", wr_addr_a, mw_a[11:8]);
        chk("a_wr_data", wr_data_a, mw_a[7:0]);
      end
    end
    if (wr_en_b === 1'b1) begin
      if (wq_b.size() == 0) unexpected("b_write");
      else begin
        mw_b = wq_b.pop_front();
        chk("b_wr_addr", wr_addr_b, mw_b[11:8]);
        chk("b_wr_data", wr_data_b, mw_b[7:0]);
      end
    end
    if (done_p_a === 1'b1) begin
      if (dq_a.size() == 0) unexpected("a_done");
      else begin
        md_a = dq_a.pop_front();
        chk("a_trig_addr", trig_addr_a, md_a[7:4]);
        chk("a_rd_base", rd_base_a, md_a[3:0]);
        chk("a_done_stop", stop_a, 1);
      end
    end
    if (done_p_b === 1'b1) begin
      if (dq_b.size() == 0) unexpected("b_done");
      else begin
        md_b = dq_b.pop_front();
        chk("b_trig_addr", trig_addr_b, md_b[7:4]);
        chk("b_rd_base", rd_base_b, md_b[3:0]);
        chk("b_done_stop", stop_b, 1);
      end
    end
  end

  initial begin
    rst = 1'b1; sample_en = 1'b0; arm_a = 1'b0; arm_b = 1'b0; abort = 1'b0; force_trig = 1'b0;
    din = 8'h00; trig_mask = 8'h00; trig_val = 8'h00; trig_edge = 8'h00;
    repeat (3) tick();
    chk("rst_state_a", state_a, 0);
    chk("rst_state_b", state_b, 0);
    chk("rst_wr_en_a", wr_en_a, 0);
    chk("rst_stop_a", stop_a, 0);
    chk("rst_wr_addr_a", wr_addr_a, 0);
    chk("rst_trig_addr_a", trig_addr_a, 0);
    chk("rst_rd_base_a", rd_base_a, 0);
    chk("rst_done_p_a", done_p_a, 0);
    rst = 1'b0;
    tick();

    // Level trigger on ch0 at the 11th sample: trig_addr 10, window base 6.
    trig_mask = 8'h01; trig_val = 8'h01; trig_edge = 8'h00;
    arm_a = 1'b1; tick(); arm_a = 1'b0; cap_a = 1'b1;
    chk("lvl_pre", state_a, 1);
    for (int i = 0; i < 4; i++) do_sample(8'(2 * i + 64));
    chk("lvl_wait", state_a, 2);
    for (int i = 4; i < 10; i++) do_sample(8'(2 * i + 64));
    chk("lvl_still_wait", state_a, 2);
    dq_a.push_back({4'd10, 4'd6});
    do_sample(8'h01);
    chk("lvl_post", state_a, 3);
    arm_a = 1'b1; tick(); arm_a = 1'b0;
    chk("arm_ignored_post", state_a, 3);
    for (int i = 0; i < 10; i++) do_sample(8'(8'h80 + i));
    chk("post_11_of_12", state_a, 3);
    do_sample(8'h8A);
    cap_a = 1'b0;
    chk("lvl_done", state_a, 4);
    chk("lvl_stop", stop_a, 1);
    chk("lvl_done_p", done_p_a, 1);
    tick();
    chk("lvl_done_p_one_clk", done_p_a, 0);
    do_sample(8'h55);
    chk("done_ignores_sample", state_a, 4);

    // Re-arm from S_DONE, then reset in the middle of S_POST.
    arm_a = 1'b1; tick(); arm_a = 1'b0; cap_a = 1'b1;
    chk("rearm_pre", state_a, 1);
    for (int i = 0; i < 4; i++) do_sample(8'(2 * i + 32));
    do_sample(8'h01);
    do_sample(8'hC3);
    do_sample(8'h3C);
    chk("mid_post", state_a, 3);
    rst = 1'b1; tick(); rst = 1'b0;
    cap_a = 1'b0; ptr_a = 4'd0;
    chk("rst_post_state", state_a, 0);
    chk("rst_post_wr_en", wr_en_a, 0);
    chk("rst_post_stop", stop_a, 0);
    chk("rst_post_wr_addr", wr_addr_a, 0);
    chk("rst_post_trig_addr", trig_addr_a, 0);

    // Pointer wrap in S_WAIT, trigger just after the wrap: base = 1 - 4 mod 16 = 13.
    arm_a = 1'b1; tick(); arm_a = 1'b0; cap_a = 1'b1;
    for (int i = 0; i < 4; i++) do_sample(8'(2 * i + 16));
    chk("wrap_wait", state_a, 2);
    for (int i = 0; i < 11; i++) do_sample(8'(2 * i + 100));
    do_sample(8'hFE);
    chk("wrap_addr_15", wr_addr_a, 15);
    do_sample(8'hEE);
    chk("wrap_addr_0", wr_addr_a, 0);
    dq_a.push_back({4'd1, 4'd13});
    do_sample(8'h01);
    for (int i = 0; i < 11; i++) do_sample(8'(8'h60 + i));
    cap_a = 1'b0;
    chk("wrap_done", state_a, 4);
    arm_a = 1'b1; abort = 1'b1; tick(); arm_a = 1'b0; abort = 1'b0;
    chk("arm_abort_idle", state_a, 0);
    chk("arm_abort_stop", stop_a, 0);
    chk("held_trig_addr", trig_addr_a, 1);
    chk("held_rd_base", rd_base_a, 13);

    // Edge trigger on ch7, PRE_TRIG=0: first sample cannot trigger, the next toggle does.
    trig_mask = 8'h00; trig_val = 8'h00; trig_edge = 8'h80;
    arm_b = 1'b1; tick(); arm_b = 1'b0; cap_b = 1'b1;
    chk("edge_direct_wait", state_b, 2);
    do_sample(8'h80);
    chk("edge_first_no_trig", state_b, 2);
    do_sample(8'h81);
    chk("edge_other_ch_no_trig", state_b, 2);
    dq_b.push_back({4'd2, 4'd2});
    do_sample(8'h01);
    chk("edge_trig", state_b, 3);
    for (int i = 0; i < 14; i++) do_sample(8'(i * 3));
    chk("edge_post_15_of_16", state_b, 3);
    do_sample(8'h77);
    cap_b = 1'b0;
    chk("edge_done", state_b, 4);

    // No masks: 1000 random samples never trigger; force_trig needs a sample.
    trig_edge = 8'h00;
    arm_a = 1'b1; tick(); arm_a = 1'b0; cap_a = 1'b1;
    for (int i = 0; i < 1000; i++) do_sample(8'($urandom));
    chk("nomask_wait", state_a, 2);
    force_trig = 1'b1; tick(); force_trig = 1'b0;
    chk("force_without_sample", state_a, 2);
    force_trig = 1'b1; do_sample(8'h3C); force_trig = 1'b0;
    chk("force_trig", state_a, 3);
    abort = 1'b1; tick(); abort = 1'b0; cap_a = 1'b0;
    chk("abort_post", state_a, 0);
    chk("abort_done", state_b, 0);

    // Auto-trigger after TIMEOUT=8 samples in S_WAIT (only with LA_AUTO_TRIG_EN).
    arm_b = 1'b1; tick(); arm_b = 1'b0; cap_b = 1'b1;
    chk("auto_wait", state_b, 2);
`ifdef LA_AUTO_TRIG_EN
    for (int i = 0; i < 7; i++) do_sample(8'(i + 1));
    chk("auto_7_no_trig", state_b, 2);
    do_sample(8'h08);
    chk("auto_8_trig", state_b, 3);
`else
    for (int i = 0; i < 20; i++) do_sample(8'(i + 1));
    chk("no_auto_trig", state_b, 2);
`endif
    abort = 1'b1; tick(); abort = 1'b0; cap_b = 1'b0;
    chk("final_abort", state_b, 0);

    repeat (3) tick();
    chk("wq_a_left", wq_a.size(), 0);
    chk("wq_b_left", wq_b.size(), 0);
    chk("dq_a_left", dq_a.size(), 0);
    chk("dq_b_left", dq_b.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
